// File: rtl/sub8b_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sub8b_pkg
// Description : Shared types and constants for the bit-serial subtractor:
//               controller state encoding and the default operand width.
// Revision    : 1.0 - initial release
// ============================================================================
package sub8b_pkg;

   // Default operand / result width in bits
   localparam int c_default_width = 8;

   // Controller states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : sub8b_pkg
`default_nettype wire

// File: rtl/sub1b_sub.sv
`default_nettype none
// ============================================================================
// Module      : sub1b_sub
// Description : Combinational one-bit full subtractor, d = a - b - bin,
//               bout set when the column has to borrow from the next bit.
// Revision    : 1.0 - initial release
// ============================================================================
module sub1b_sub (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   // Difference is the parity of the three inputs; borrow when b+bin exceeds a
   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : sub1b_sub
`default_nettype wire

// File: rtl/sub8b_serial.sv
`default_nettype none
// ============================================================================
// Module      : sub8b_serial
// Description : Bit-serial unsigned subtractor, D = A - B - Bi (mod 2^WIDTH),
//               Bout = borrow-out. One bit pair per clock, LSB first, through
//               a single full-subtractor cell. Result lands WIDTH edges after
//               the capturing edge, flagged by a one-cycle done pulse.
//               Optional macro SUB8B_SERIAL_ZERO_FLAG_EN adds zero flag Z.
// Revision    : 1.0 - initial release
// ============================================================================
module sub8b_serial
   import sub8b_pkg::*;
#(
   parameter int WIDTH = c_default_width
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bi,
   output logic [WIDTH-1:0] D,
   output logic             Bout,
   output logic             busy,
   output logic             done
`ifdef SUB8B_SERIAL_ZERO_FLAG_EN
   ,
   output logic             Z
`endif
);

   // Counter is wide enough to hold WIDTH itself, so it never wraps
   localparam int                  c_cnt_w = $clog2(WIDTH + 1);
   localparam logic [c_cnt_w-1:0]  c_last  = c_cnt_w'(WIDTH - 1);

   state_t             r_state;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_dacc;
   logic               r_borrow;
   logic [c_cnt_w-1:0] r_cnt;

   logic               w_d;
   logic               w_bout;
   logic [WIDTH-1:0]   w_dnext;

   sub1b_sub u_cell (
      .a    (r_a[0]),
      .b    (r_b[0]),
      .bin  (r_borrow),
      .d    (w_d),
      .bout (w_bout)
   );

   // New difference bit enters at the MSB; after WIDTH shifts bit 0 sits at LSB
   assign w_dnext = (r_dacc >> 1) | (WIDTH'(w_d) << (WIDTH - 1));

   // Controller, datapath shift registers and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_dacc   <= '0;
         r_borrow <= 1'b0;
         r_cnt    <= '0;
         D        <= '0;
         Bout     <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
`ifdef SUB8B_SERIAL_ZERO_FLAG_EN
         Z        <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_a      <= A;
                  r_b      <= B;
                  r_borrow <= Bi;
                  r_dacc   <= '0;
                  r_cnt    <= '0;
                  busy     <= 1'b1;
                  r_state  <= RUN;
               end
            end
            RUN: begin
               r_a      <= r_a >> 1;
               r_b      <= r_b >> 1;
               r_borrow <= w_bout;
               r_dacc   <= w_dnext;
               r_cnt    <= r_cnt + 1'b1;
               if (r_cnt == c_last) begin
                  // Outputs change only here, so an aborted run never shows
                  D       <= w_dnext;
                  Bout    <= w_bout;
`ifdef SUB8B_SERIAL_ZERO_FLAG_EN
                  Z       <= (w_dnext == '0);
`endif
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  r_state <= DONE;
               end
            end
            DONE: begin
               done    <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule : sub8b_serial
`default_nettype wire

// File: doc/sub8b_serial.md
SUB8B_SERIAL -- requirements
Module: sub8b_serial

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a subtraction.
REQ-005 The block SHALL have port A, input, WIDTH bits: minuend, unsigned.
REQ-006 The block SHALL have port B, input, WIDTH bits: subtrahend, unsigned.
REQ-007 The block SHALL have port Bi, input, 1 bit: borrow-in.
REQ-008 The block SHALL have port D, output, WIDTH bits: difference, registered.
REQ-009 The block SHALL have port Bout, output, 1 bit: borrow-out, registered.
REQ-010 The block SHALL have port busy, output, 1 bit: high while the state is RUN.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle result-valid pulse.

Function
REQ-012 The block SHALL compute D = (A - B - Bi) mod 2^WIDTH and set Bout = 1 exactly when A < B + Bi (unsigned).
REQ-013 The block SHALL use a three-state FSM with states IDLE, RUN and DONE.
REQ-014 In IDLE, start=1 at a clock edge SHALL capture A, B and Bi into internal shift registers, load the borrow flop with Bi, clear the bit counter and move to RUN.
REQ-015 In RUN, each edge SHALL process exactly one bit pair, LSB first, through one full-subtractor cell, shift the difference bit into the result register from the MSB side, and update the borrow flop.
REQ-016 After WIDTH RUN edges, the FSM SHALL enter DONE; with start captured at edge k, done SHALL be high in the cycle following edge k+WIDTH (k+8 for WIDTH=8).
REQ-017 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-018 D and Bout SHALL update only on the DONE entry edge and hold their value until the next completed operation.
REQ-019 start in RUN or DONE SHALL be ignored, with no effect on the operation in flight and no queuing.
REQ-020 Input changes on A, B and Bi after capture SHALL NOT affect the result.
REQ-021 busy SHALL be 1 in RUN only; done SHALL be 1 in DONE only; the two are never high together.
REQ-022 start held continuously high SHALL produce back-to-back operations with period WIDTH+2 cycles.
REQ-023 The bit counter SHALL be $clog2(WIDTH+1) bits wide and SHALL NOT wrap during an operation.

Reset
REQ-024 rst_n=0 SHALL immediately force state IDLE, D=0, Bout=0, busy=0, done=0, borrow flop=0, counter=0 and clear the shift registers.
REQ-025 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow, and the aborted operation SHALL leave no partial result on D.
REQ-026 After release, the block SHALL accept start on the first rising edge.

Configuration
REQ-027 With macro SUB8B_SERIAL_ZERO_FLAG_EN defined, the block SHALL add output Z, 1 bit, registered, set to 1 when the result D is all zeros.
REQ-028 Z SHALL update with D, reset to 0, and hold with D.
REQ-029 Without SUB8B_SERIAL_ZERO_FLAG_EN, port Z and its logic SHALL be absent.

Structure
REQ-030 Package sub8b_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and the default-width constant.
REQ-031 The block SHALL instantiate one sub-module, sub1b_sub, a combinational full-subtractor with inputs a, b, bin and outputs d, bout.

Verification
REQ-032 The bench SHALL check: A=0x50, B=0x20, Bi=0, start at edge 0 -> done in the cycle after edge 8, D=0x30, Bout=0, busy high for 8 cycles.
REQ-033 The bench SHALL check: A=0x00, B=0x01, Bi=0 -> D=0xFF, Bout=1.
REQ-034 The bench SHALL check: A=0xFF, B=0xFF, Bi=1 -> D=0xFF, Bout=1; and A=0xFF, B=0xFE, Bi=1 -> D=0x00, Bout=0 (Z=1 when the macro is defined).
REQ-035 The bench SHALL check: start re-pulsed during RUN with different operands -> only the first result appears, with exactly one done pulse.
REQ-036 The bench SHALL check: rst_n low at the 4th RUN cycle -> outputs read 0 immediately, no done follows, and a new start after release gives the correct result.
REQ-037 The bench SHALL check: start held high with 3 operand sets -> done pulses 10 cycles apart with correct D and Bout for each.
